// File: rtl/if_fetch_unit_pkg.sv
// Shared RV32I fetch-stage types and constants: word width, canonical NOP,
// default reset PC and the {pc, instr} fetch queue entry.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t NOP_INSTR        = 32'h0000_0013;
  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic word_t next_pc(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction memory request/response bus seen from the fetch unit.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  // Handshake: a request transfers on a cycle with imem_req && imem_gnt; while
  // imem_req is high without imem_gnt the address is held stable. Responses
  // (imem_rvalid) arrive in request order, at least one cycle after the grant,
  // and cannot be back-pressured by the fetch unit.
  logic  imem_req;
  word_t imem_addr;
  logic  imem_gnt;
  logic  imem_rvalid;
  word_t imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Two-entry synchronous FIFO with flush and occupancy count; slot0 is always
// the head so the read side needs no pointer.
module fetch_fifo #(
    parameter int W = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;
    logic [1:0]   after_pop;
    logic         pop_ok;
    logic         push_ok;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

    always_comb begin
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        after_pop = count_q;
        if (pop_ok) begin
            slot0_d   = slot1_q;
            after_pop = count_q - 2'd1;
        end
        if (push_ok) begin
            if (after_pop == 2'd0) begin
                slot0_d = push_data_i;
            end else begin
                slot1_d = push_data_i;
            end
        end
        count_d = after_pop + {1'b0, push_ok};
        if (flush_i) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch stage: PC register, credit-limited imem requests,
// pending-PC and fetch queues, stall hold and self-flushing redirect.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   stall_if_i,
    input  logic                   take_b_j_i,
    input  word_t                  target_pc_i,
    if_fetch_unit_if.master        imem,
    output logic                   if_valid_o,
    output word_t                  if_pc_o,
    output word_t                  if_instr_o
);

    word_t        pc_q, pc_d;
    logic [1:0]   out_cnt_q, out_cnt_d;
    logic [1:0]   drop_cnt_q, drop_cnt_d;

    fetch_entry_t fq_head;
    fetch_entry_t fq_push_data;
    logic [1:0]   fq_count;
    logic [1:0]   fq_after_pop;
    word_t        pq_head;
    logic [1:0]   pq_count;

    logic         req;
    logic         grant;
    logic         rsp;
    logic         rsp_keep;
    logic         fq_pop;
    logic [2:0]   credit_used;
    logic         unused_tgt_lsbs;

    assign unused_tgt_lsbs = ^target_pc_i[1:0];

    assign if_valid_o = (fq_count != 2'd0) && !take_b_j_i;
    assign fq_pop     = if_valid_o && !stall_if_i;
    assign if_pc_o    = (fq_count != 2'd0) ? fq_head.pc : pc_q;
    assign if_instr_o = if_valid_o ? fq_head.instr : NOP_INSTR;

    // Credit counts the fetch queue after this cycle's pop, which is what lets
    // an unstalled pipe with 1-cycle memory issue a request every cycle.
    assign fq_after_pop = fq_count - {1'b0, fq_pop};
    assign credit_used  = {1'b0, out_cnt_q} + {1'b0, fq_after_pop};
    assign req          = rst_ni && !take_b_j_i && (credit_used < 3'd2);
    assign grant        = req && imem.imem_gnt;

    assign rsp      = imem.imem_rvalid && (pq_count != 2'd0);
    assign rsp_keep = rsp && (drop_cnt_q == 2'd0) && !take_b_j_i;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    assign fq_push_data = {pq_head, imem.imem_rdata};

    always_comb begin
        pc_d       = pc_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (take_b_j_i) begin
            pc_d = {target_pc_i[XLEN-1:2], 2'b00};
        end else if (grant) begin
            pc_d = next_pc(pc_q);
        end

        case ({grant, rsp})
            2'b10:   out_cnt_d = out_cnt_q + 2'd1;
            2'b01:   out_cnt_d = out_cnt_q - 2'd1;
            default: out_cnt_d = out_cnt_q;
        endcase

        // After a redirect every response still in flight belongs to the old path.
        if (take_b_j_i) begin
            drop_cnt_d = rsp ? (out_cnt_q - 2'd1) : out_cnt_q;
        end else if (rsp && (drop_cnt_q != 2'd0)) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q       <= RESET_PC;
            out_cnt_q  <= 2'd0;
            drop_cnt_q <= 2'd0;
        end else begin
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .W($bits(fetch_entry_t))
    ) u_fetch_q (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (take_b_j_i),
        .push_i     (rsp_keep),
        .push_data_i(fq_push_data),
        .pop_i      (fq_pop),
        .head_o     (fq_head),
        .count_o    (fq_count)
    );

    // Pending-PC queue is never flushed: its entries track responses that will
    // still arrive, stale or not.
    fetch_fifo #(
        .W(XLEN)
    ) u_pend_q (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .push_i     (grant),
        .push_data_i(pc_q),
        .pop_i      (rsp),
        .head_o     (pq_head),
        .count_o    (pq_count)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: memory model with random grant/latency,
// queue-based reference of the fetch stream, mid-stream reset.
module tb_if_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stall_if_i;
  logic        take_b_j_i;
  logic [31:0] target_pc_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;

  if_fetch_unit_if imem_bus ();

  if_fetch_unit dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .stall_if_i (stall_if_i),
    .take_b_j_i (take_b_j_i),
    .target_pc_i(target_pc_i),
    .imem       (imem_bus),
    .if_valid_o (if_valid_o),
    .if_pc_o    (if_pc_o),
    .if_instr_o (if_instr_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  localparam logic [31:0] EXP_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EXP_NOP      = 32'h0000_0013;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } infl_t;
  infl_t       infl_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;

  // memory model state
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          cyc = 0;
  int          p_gnt = 100;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, imem_bus.imem_req}, 32'd0);
    check({tag, "_valid"}, {31'd0, if_valid_o}, 32'd0);
    check({tag, "_instr"}, if_instr_o, EXP_NOP);
    check({tag, "_pc"},    if_pc_o, EXP_RESET_PC);
  endtask

  task automatic model_clear();
    infl_q.delete();
    exp_q.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
    m_pc = EXP_RESET_PC;
  endtask

  // driver: asserts reset asynchronously mid-cycle, releases just after a rising edge
  task automatic do_reset();
    @(negedge clk_i);
    stall_if_i = 1'b0;
    take_b_j_i = 1'b0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("rst_async");
    model_clear();
    repeat (2) @(posedge clk_i);
    #1 check_reset_outputs("rst_hold");
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // driver + checker for one clock cycle
  task automatic step(input bit take, input logic [31:0] tgt, input bit stall);
    bit          rv;
    bit          g;
    bit          e_req;
    bit          e_valid;
    bit          pop;
    logic [31:0] rd_addr;
    infl_t       it;
    @(negedge clk_i);
    stall_if_i  = stall;
    take_b_j_i  = take;
    target_pc_i = tgt;
    rv = (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
    if (rv) begin
      rd_addr = mem_addr_q.pop_front();
      void'(mem_due_q.pop_front());
      imem_bus.imem_rdata = word_at(rd_addr);
    end else begin
      imem_bus.imem_rdata = $urandom;
    end
    imem_bus.imem_rvalid = rv;
    #1;
    e_valid = !take && (exp_q.size() > 0);
    pop     = e_valid && !stall;
    e_req   = !take && ((infl_q.size() + exp_q.size() - (pop ? 1 : 0)) < 2);
    g = imem_bus.imem_req && ($urandom_range(99) < p_gnt);
    imem_bus.imem_gnt = g;
    #1;
    check("req", {31'd0, imem_bus.imem_req}, {31'd0, e_req});
    if (e_req) check("addr", imem_bus.imem_addr, m_pc);
    check("valid", {31'd0, if_valid_o}, {31'd0, e_valid});
    if (e_valid) begin
      check("pc", if_pc_o, exp_q[0]);
      check("instr", if_instr_o, word_at(exp_q[0]));
    end else begin
      check("nop", if_instr_o, EXP_NOP);
    end
    // reference update for the coming rising edge
    if (take) begin
      exp_q.delete();
      if (rv && infl_q.size() > 0) void'(infl_q.pop_front());
      foreach (infl_q[i]) infl_q[i].stale = 1'b1;
      m_pc = {tgt[31:2], 2'b00};
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (rv && infl_q.size() > 0) begin
        it = infl_q.pop_front();
        if (!it.stale) exp_q.push_back(it.pc);
      end
      if (g && e_req) begin
        infl_q.push_back('{pc: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    if (g) begin
      mem_addr_q.push_back(imem_bus.imem_addr);
      mem_due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    cyc++;
  endtask

  task automatic run_plain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(4))
      0:       return 32'h0000_0100;
      1:       return 32'h0000_0203;
      2:       return 32'hFFFF_FFF8;
      3:       return 32'hFFFF_FFFC;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_random(input int n, input int p_stall, input int p_take);
    bit t;
    bit s;
    for (int i = 0; i < n; i++) begin
      t = ($urandom_range(99) < p_take);
      s = ($urandom_range(99) < p_stall);
      step(t, pick_target(), s);
    end
  endtask

  initial begin
    stall_if_i  = 1'b0;
    take_b_j_i  = 1'b0;
    target_pc_i = 32'h0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    model_clear();
    #3 check_reset_outputs("rst_init");
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // streaming, 1-cycle memory, then a 4-cycle stall
    p_gnt = 100; lat_min = 1; lat_max = 1;
    run_plain(30);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    run_plain(10);

    // two outstanding with 3-cycle latency, then redirect to 0x100
    lat_min = 3; lat_max = 3;
    run_plain(6);
    step(1'b1, 32'h0000_0100, 1'b0);
    run_plain(15);

    // redirect coinciding with a response while stalled, unaligned target
    lat_min = 1; lat_max = 1;
    run_plain(8);
    step(1'b1, 32'h0000_0203, 1'b1);
    run_plain(10);

    // address wrap past 0xFFFF_FFFC
    step(1'b1, 32'hFFFF_FFF8, 1'b0);
    run_plain(10);

    // randomized grant, latency, stall and redirect
    p_gnt = 70; lat_min = 1; lat_max = 4;
    run_random(1500, 25, 8);

    // reset with requests in flight
    p_gnt = 100; lat_min = 3; lat_max = 3;
    run_plain(5);
    do_reset();
    run_plain(12);
    p_gnt = 60; lat_min = 1; lat_max = 3;
    run_random(300, 20, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
